// File: rtl/demod_stream_arbiter_if.sv
// AXI-Stream style bundle shared by requester, resource and result ports
// of the demodulator stream arbiter.

// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; tdata/tlast are only meaningful while tvalid is high.
interface demod_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [DATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/demod_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one order-preserving demod stage
// between two IQ requesters; a tag FIFO steers returning results per channel.

module demod_stream_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  demod_stream_arbiter_if.slave           s00_axis,
  demod_stream_arbiter_if.slave           s01_axis,
  demod_stream_arbiter_if.master          m_res_axis,
  demod_stream_arbiter_if.slave           s_res_axis,
  demod_stream_arbiter_if.master          m00_axis,
  demod_stream_arbiter_if.master          m01_axis,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic [1:0]                      dbg_state
);

  localparam int CW = $clog2(MAX_INFLIGHT);
  localparam logic [CW:0] FULL_CNT = (CW + 1)'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state, state_nxt;
  logic          last_grant;
  logic [CW:0]   count;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic          tag_mem [MAX_INFLIGHT];

  logic full, empty, push, pop, issue_tag, head_tag, head_busy;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign inflight  = count;
  assign dbg_state = state;

  // Arbitration and combinational issue path
  always_comb begin
    state_nxt         = state;
    issue_tag         = 1'b0;
    s00_axis.tready   = 1'b0;
    s01_axis.tready   = 1'b0;
    m_res_axis.tvalid = 1'b0;
    m_res_axis.tlast  = 1'b0;
    m_res_axis.tdata  = '0;
    case (state)
      IDLE: begin
        if (s00_axis.tvalid && s01_axis.tvalid)
          state_nxt = last_grant ? GRANT0 : GRANT1;
        else if (s00_axis.tvalid)
          state_nxt = GRANT0;
        else if (s01_axis.tvalid)
          state_nxt = GRANT1;
      end
      GRANT0: begin
        m_res_axis.tvalid = s00_axis.tvalid && !full;
        m_res_axis.tlast  = s00_axis.tlast;
        m_res_axis.tdata  = s00_axis.tdata;
        s00_axis.tready   = m_res_axis.tready && !full;
        if (m_res_axis.tvalid && m_res_axis.tready && s00_axis.tlast)
          state_nxt = IDLE;
      end
      GRANT1: begin
        issue_tag         = 1'b1;
        m_res_axis.tvalid = s01_axis.tvalid && !full;
        m_res_axis.tlast  = s01_axis.tlast;
        m_res_axis.tdata  = s01_axis.tdata;
        s01_axis.tready   = m_res_axis.tready && !full;
        if (m_res_axis.tvalid && m_res_axis.tready && s01_axis.tlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push = m_res_axis.tvalid && m_res_axis.tready;

  // Head-of-line: the oldest tag's output must have room before any result moves
  assign head_tag  = tag_mem[rd_ptr];
  assign head_busy = head_tag ? (m01_axis.tvalid && !m01_axis.tready)
                              : (m00_axis.tvalid && !m00_axis.tready);
  assign s_res_axis.tready = !empty && !head_busy;
  assign pop = s_res_axis.tvalid && s_res_axis.tready;

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == GRANT0) last_grant <= 1'b0;
      if (state == IDLE && state_nxt == GRANT1) last_grant <= 1'b1;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (push) tag_mem[wr_ptr] <= issue_tag;
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result registers: a new load for a channel wins over its own handshake clear
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis.tvalid <= 1'b0;
      m00_axis.tlast  <= 1'b0;
      m00_axis.tdata  <= '0;
      m01_axis.tvalid <= 1'b0;
      m01_axis.tlast  <= 1'b0;
      m01_axis.tdata  <= '0;
    end else begin
      if (pop && !head_tag) begin
        m00_axis.tvalid <= 1'b1;
        m00_axis.tlast  <= s_res_axis.tlast;
        m00_axis.tdata  <= s_res_axis.tdata;
      end else if (m00_axis.tready) begin
        m00_axis.tvalid <= 1'b0;
      end
      if (pop && head_tag) begin
        m01_axis.tvalid <= 1'b1;
        m01_axis.tlast  <= s_res_axis.tlast;
        m01_axis.tdata  <= s_res_axis.tdata;
      end else if (m01_axis.tready) begin
        m01_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demod_stream_arbiter.sv
// Directed bench for demod_stream_arbiter: queue-based behavioural model checked
// every cycle, an echoing resource with fixed latency, and literal pins.

module tb_demod_stream_arbiter;

  localparam int DW   = 32;
  localparam int MAXI = 8;
  localparam int CW   = $clog2(MAXI);
  localparam int LAT  = 3;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
    int            t;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW:0] inflight;
  logic [1:0]  dbg_state;

  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) s00_axis ();
  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) s01_axis ();
  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) m_res_axis ();
  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) s_res_axis ();
  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) m00_axis ();
  demod_stream_arbiter_if #(.DATA_WIDTH(DW)) m01_axis ();

  demod_stream_arbiter #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MAXI)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis         (s00_axis),
    .s01_axis         (s01_axis),
    .m_res_axis       (m_res_axis),
    .s_res_axis       (s_res_axis),
    .m00_axis         (m00_axis),
    .m01_axis         (m01_axis),
    .inflight         (inflight),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state (owned by compare process) ----------------
  int            m_owner;
  int            m_last;
  int            m_tags[$];
  logic          m_ov[2];
  logic          m_ol[2];
  logic [DW-1:0] m_od[2];
  logic [DW:0]   exp_q0[$];
  logic [DW:0]   exp_q1[$];
  logic [DW:0]   out_log0[$];
  logic [DW:0]   out_log1[$];
  int            glog[$];
  res_t          res_q[$];
  int            issue_cnt, res_cnt, peak;
  logic          pkt_start;

  // ---------------- resource model / driver ----------------
  int   cyc = 0;
  int   res_limit = -1;
  logic spur = 1'b0;

  initial begin
    s_res_axis.tvalid = 1'b0;
    s_res_axis.tlast  = 1'b0;
    s_res_axis.tdata  = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (!rst_n) begin
        s_res_axis.tvalid = 1'b0;
      end else if (spur) begin
        s_res_axis.tvalid = 1'b1;
        s_res_axis.tlast  = 1'b0;
        s_res_axis.tdata  = 32'hdead_beef;
      end else if (res_q.size() > 0 && res_q[0].t + LAT <= cyc &&
                   (res_limit < 0 || res_cnt < res_limit)) begin
        s_res_axis.tvalid = 1'b1;
        s_res_axis.tlast  = res_q[0].l;
        s_res_axis.tdata  = res_q[0].d;
      end else begin
        s_res_axis.tvalid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin : cmp
    logic          e_full, e_empty, e_rv, e_rl, e_sr, issue, pop;
    logic          e_r[2];
    logic          o_rdy[2];
    logic [DW-1:0] e_rd;
    logic [DW:0]   got, want;
    int            h;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_tags.delete();
      for (int c = 0; c < 2; c++) begin m_ov[c] = 0; m_ol[c] = 0; m_od[c] = '0; end
      exp_q0.delete(); exp_q1.delete(); res_q.delete();
      out_log0.delete(); out_log1.delete(); glog.delete();
      issue_cnt = 0; res_cnt = 0; peak = 0; pkt_start = 1'b1;
    end
    o_rdy[0] = m00_axis.tready;
    o_rdy[1] = m01_axis.tready;
    e_full  = (m_tags.size() == MAXI);
    e_empty = (m_tags.size() == 0);
    e_rv = 0; e_rl = 0; e_rd = '0; e_r[0] = 0; e_r[1] = 0;
    if (m_owner == 0) begin
      e_rv = s00_axis.tvalid && !e_full; e_rd = s00_axis.tdata; e_rl = s00_axis.tlast;
      e_r[0] = m_res_axis.tready && !e_full;
    end else if (m_owner == 1) begin
      e_rv = s01_axis.tvalid && !e_full; e_rd = s01_axis.tdata; e_rl = s01_axis.tlast;
      e_r[1] = m_res_axis.tready && !e_full;
    end
    h = e_empty ? 0 : m_tags[0];
    e_sr = !e_empty && (!m_ov[h] || o_rdy[h]);

    check("m_res_tvalid", 64'(m_res_axis.tvalid), 64'(e_rv));
    if (e_rv) begin
      check("m_res_tdata", 64'(m_res_axis.tdata), 64'(e_rd));
      check("m_res_tlast", 64'(m_res_axis.tlast), 64'(e_rl));
    end
    check("s00_tready", 64'(s00_axis.tready), 64'(e_r[0]));
    check("s01_tready", 64'(s01_axis.tready), 64'(e_r[1]));
    check("s_res_tready", 64'(s_res_axis.tready), 64'(e_sr));
    check("inflight", 64'(inflight), 64'(m_tags.size()));
    check("m00_tvalid", 64'(m00_axis.tvalid), 64'(m_ov[0]));
    check("m00_tdata", 64'(m00_axis.tdata), 64'(m_od[0]));
    check("m00_tlast", 64'(m00_axis.tlast), 64'(m_ol[0]));
    check("m01_tvalid", 64'(m01_axis.tvalid), 64'(m_ov[1]));
    check("m01_tdata", 64'(m01_axis.tdata), 64'(m_od[1]));
    check("m01_tlast", 64'(m01_axis.tlast), 64'(m_ol[1]));

    if (rst_n) begin
      if (int'(inflight) > peak) peak = int'(inflight);
      // scoreboard: each delivered result must be the next beat its channel issued
      if (m_ov[0] && o_rdy[0]) begin
        got = {m00_axis.tlast, m00_axis.tdata};
        out_log0.push_back(got);
        if (exp_q0.size() == 0) check("sb_ch0_unexpected", 64'(got), 64'd0);
        else begin want = exp_q0.pop_front(); check("sb_ch0", 64'(got), 64'(want)); end
      end
      if (m_ov[1] && o_rdy[1]) begin
        got = {m01_axis.tlast, m01_axis.tdata};
        out_log1.push_back(got);
        if (exp_q1.size() == 0) check("sb_ch1_unexpected", 64'(got), 64'd0);
        else begin want = exp_q1.pop_front(); check("sb_ch1", 64'(got), 64'(want)); end
      end

      issue = e_rv && m_res_axis.tready;
      pop   = s_res_axis.tvalid && e_sr;
      for (int c = 0; c < 2; c++) begin
        if (pop && h == c) begin
          m_ov[c] = 1'b1; m_od[c] = s_res_axis.tdata; m_ol[c] = s_res_axis.tlast;
        end else if (o_rdy[c]) begin
          m_ov[c] = 1'b0;
        end
      end
      if (pop) begin
        void'(m_tags.pop_front());
        void'(res_q.pop_front());
        res_cnt++;
      end
      if (issue) begin
        m_tags.push_back(m_owner);
        if (m_owner == 0) exp_q0.push_back({e_rl, e_rd});
        else              exp_q1.push_back({e_rl, e_rd});
        res_q.push_back('{d: e_rd, l: e_rl, t: cyc});
        issue_cnt++;
        if (pkt_start) glog.push_back(m_owner);
        pkt_start = e_rl;
      end
      if (m_owner == -1) begin
        if (s00_axis.tvalid && s01_axis.tvalid) m_owner = (m_last == 1) ? 0 : 1;
        else if (s00_axis.tvalid)               m_owner = 0;
        else if (s01_axis.tvalid)               m_owner = 1;
        if (m_owner != -1) m_last = m_owner;
      end else if (issue && e_rl) begin
        m_owner = -1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_src(input int ch, input logic v, input logic [DW-1:0] d, input logic l);
    if (ch == 0) begin
      s00_axis.tvalid = v; s00_axis.tdata = d; s00_axis.tlast = l;
    end else begin
      s01_axis.tvalid = v; s01_axis.tdata = d; s01_axis.tlast = l;
    end
  endtask

  function automatic logic src_rdy(input int ch);
    return (ch == 0) ? s00_axis.tready : s01_axis.tready;
  endfunction

  task automatic send_pkt(input int ch, input int n, input logic [DW-1:0] base);
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      drive_src(ch, 1'b1, base + DW'(i), (i == n - 1));
      forever begin
        @(negedge clk);
        if (src_rdy(ch)) break;
        w++;
        if (w > 400) break;
      end
      if (w > 400) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout ch=%0d actual=no_ready required=ready", ch);
      end
      @(posedge clk); #1;
    end
    drive_src(ch, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (m_tags.size() == 0 && res_q.size() == 0 && !m_ov[0] && !m_ov[1] && m_owner == -1) break;
      w++;
      if (w > 500) begin
        n_vec++; n_err++;
        $display("FAIL drain_timeout actual=busy required=idle");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    drive_src(0, 1'b0, '0, 1'b0);
    drive_src(1, 1'b0, '0, 1'b0);
    m_res_axis.tready = 1'b1;
    m00_axis.tready   = 1'b1;
    m01_axis.tready   = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // single requester, 4-beat packet echoed with latency 3
    send_pkt(0, 4, 32'h1);
    wait_drain();
    check("t1_ch0_beats", 64'(out_log0.size()), 64'd4);
    if (out_log0.size() == 4) begin
      check("t1_beat0", 64'(out_log0[0]), {31'd0, 1'b0, 32'h1});
      check("t1_beat1", 64'(out_log0[1]), {31'd0, 1'b0, 32'h2});
      check("t1_beat2", 64'(out_log0[2]), {31'd0, 1'b0, 32'h3});
      check("t1_beat3", 64'(out_log0[3]), {31'd0, 1'b1, 32'h4});
    end
    check("t1_ch1_beats", 64'(out_log1.size()), 64'd0);
    check("t1_peak_inflight", 64'(peak), 64'd3);
    check("t1_inflight_end", 64'(inflight), 64'd0);

    // tie from reset, alternating 2-beat packets
    do_reset();
    fork
      begin send_pkt(0, 2, 32'h100); send_pkt(0, 2, 32'h110); end
      begin send_pkt(1, 2, 32'h200); send_pkt(1, 2, 32'h210); end
    join
    wait_drain();
    check("t2_grants", 64'(glog.size()), 64'd4);
    if (glog.size() == 4) begin
      check("t2_grant0", 64'(glog[0]), 64'd0);
      check("t2_grant1", 64'(glog[1]), 64'd1);
      check("t2_grant2", 64'(glog[2]), 64'd0);
      check("t2_grant3", 64'(glog[3]), 64'd1);
    end
    check("t2_ch0_beats", 64'(out_log0.size()), 64'd4);
    check("t2_ch1_beats", 64'(out_log1.size()), 64'd4);

    // FIFO full with a silent resource, then release one result
    do_reset();
    res_limit = 0;
    fork
      send_pkt(0, 10, 32'h300);
    join_none
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t3_issues_full", 64'(issue_cnt), 64'd8);
    check("t3_s00_tready_full", 64'(s00_axis.tready), 64'd0);
    check("t3_inflight_full", 64'(inflight), 64'd8);
    res_limit = 1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("t3_issues_after_one", 64'(issue_cnt), 64'd9);
    check("t3_inflight_after_one", 64'(inflight), 64'd8);
    res_limit = -1;
    wait fork;
    wait_drain();
    check("t3_ch0_beats", 64'(out_log0.size()), 64'd10);

    // output backpressure with channel 1 results queued behind channel 0
    do_reset();
    m00_axis.tready = 1'b0;
    send_pkt(0, 2, 32'h400);
    send_pkt(1, 2, 32'h500);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t4_s_res_tready_stall", 64'(s_res_axis.tready), 64'd0);
    check("t4_m00_tvalid_held", 64'(m00_axis.tvalid), 64'd1);
    check("t4_m00_tdata_held", 64'(m00_axis.tdata), 64'h400);
    check("t4_m01_tvalid_blocked", 64'(m01_axis.tvalid), 64'd0);
    @(posedge clk); #1;
    m00_axis.tready = 1'b1;
    wait_drain();
    check("t4_ch1_beats", 64'(out_log1.size()), 64'd2);
    if (out_log1.size() == 2) begin
      check("t4_ch1_first", 64'(out_log1[0]), {31'd0, 1'b0, 32'h500});
      check("t4_ch1_second", 64'(out_log1[1]), {31'd0, 1'b1, 32'h501});
    end

    // reset mid-packet with two beats in flight
    do_reset();
    res_limit = 0;
    drive_src(0, 1'b1, 32'h600, 1'b0);
    begin
      int w;
      w = 0;
      forever begin
        @(negedge clk);
        if (issue_cnt >= 2) break;
        w++;
        if (w > 50) begin
          n_vec++; n_err++;
          $display("FAIL t5_issue_timeout actual=%0d required=2", issue_cnt);
          break;
        end
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_src(0, 1'b0, '0, 1'b0);
    @(negedge clk);
    check("t5_inflight_in_reset", 64'(inflight), 64'd0);
    check("t5_m_res_tvalid_in_reset", 64'(m_res_axis.tvalid), 64'd0);
    check("t5_m00_tvalid_in_reset", 64'(m00_axis.tvalid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    res_limit = -1;
    fork
      send_pkt(0, 2, 32'h700);
      send_pkt(1, 2, 32'h800);
    join
    wait_drain();
    check("t5_first_grant", 64'(glog.size() > 0 ? glog[0] : -1), 64'd0);
    check("t5_ch0_beats", 64'(out_log0.size()), 64'd2);

    // spurious result with empty FIFO
    spur = 1'b1;
    @(posedge clk); #2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_s_res_tready", 64'(s_res_axis.tready), 64'd0);
      check("t6_m00_tvalid", 64'(m00_axis.tvalid), 64'd0);
      check("t6_m01_tvalid", 64'(m01_axis.tvalid), 64'd0);
    end
    @(posedge clk); #1;
    spur = 1'b0;
    repeat (3) @(posedge clk);

    check("end_exp_q0_empty", 64'(exp_q0.size()), 64'd0);
    check("end_exp_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
